// File: rtl/tdc_read.sv
// -----------------------------------------------------------------------------
// tdc_read
//
// Purpose:
//   Interrupt-driven reader for the result registers of an external TDC.
//   When the TDC pulls int_n low (and its configuration is complete), the
//   block requests the shared chip bus, then reads NUM_REG consecutive
//   registers starting at ADDR_BASE using a CSN_o/RDN_o strobe protocol.
//   Each captured word is offered on a valid/ready interface; the bus is held
//   until every register of the sequence has been handed off.
//
// Parameters:
//   RD_SETUP   cycles with CSN_o low and addr stable before RDN_o falls (1..15)
//   RD_PULSE   cycles RDN_o is held low (1..15)
//   NUM_REG    result registers read per interrupt (1..8)
//   ADDR_BASE  address of the first result register
//
// Ports:
//   clk           system clock (single clock domain)
//   reset         synchronous, active-high reset
//   init_done     high once TDC configuration writes are complete
//   int_n         TDC interrupt, active low, asynchronous to clk
//   bus_gnt       chip bus granted to this block
//   bus_req       chip bus request
//   CSN_o         chip select, active low
//   RDN_o         read strobe, active low
//   addr          register address
//   data_i        read data from the TDC bus (never driven by this block)
//   result        captured register value
//   result_addr   address the current result was read from
//   result_valid  result available
//   result_ready  consumer accepts result
//   busy          read sequence in progress
//   overrun       sticky: interrupt seen while a sequence was pending/active
// -----------------------------------------------------------------------------
module tdc_read #(
   parameter int unsigned RD_SETUP  = 2,
   parameter int unsigned RD_PULSE  = 3,
   parameter int unsigned NUM_REG   = 2,
   parameter logic [3:0]  ADDR_BASE = 4'd8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        init_done,
   input  logic        int_n,
   input  logic        bus_gnt,
   output logic        bus_req,
   output logic        CSN_o,
   output logic        RDN_o,
   output logic [3:0]  addr,
   input  logic [27:0] data_i,
   output logic [27:0] result,
   output logic [3:0]  result_addr,
   output logic        result_valid,
   input  logic        result_ready,
   output logic        busy,
   output logic        overrun
);

   localparam logic [3:0] SetupLast = 4'(RD_SETUP - 1);
   localparam logic [3:0] PulseLast = 4'(RD_PULSE - 1);
   localparam logic [3:0] NumReg    = 4'(NUM_REG);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StSetup,
      StStrobe,
      StHold,
      StNext,
      StDone
   } state_e;

   state_e      r_state;
   state_e      w_state_next;

   // Interrupt synchronizer; r_sync3 is only the edge-detect history flop.
   logic        r_sync1;
   logic        r_sync2;
   logic        r_sync3;
   logic        w_sync_edge;

   logic        r_int_pend;
   // Remembers one interrupt that arrived while a sequence was running, so
   // exactly one further sequence follows DONE however many edges arrived.
   logic        r_requeue;
   logic        r_overrun;
   logic [2:0]  r_idx;
   logic [3:0]  r_cnt;
   logic [27:0] r_result;
   logic [3:0]  r_result_addr;

   logic        w_setup_done;
   logic        w_pulse_done;
   logic [3:0]  w_idx_inc;
   logic        w_more;
   logic [3:0]  w_addr_cur;
   logic        w_addr_en;

   assign w_sync_edge  = r_sync3 & ~r_sync2;
   assign w_setup_done = (r_cnt == SetupLast);
   assign w_pulse_done = (r_cnt == PulseLast);
   assign w_idx_inc    = {1'b0, r_idx} + 4'd1;
   assign w_more       = (w_idx_inc < NumReg);
   // 4-bit wrap of the register address is intentional.
   assign w_addr_cur   = ADDR_BASE + {1'b0, r_idx};

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (r_int_pend && init_done) begin
               w_state_next = StReq;
            end
         end
         StReq: begin
            if (bus_gnt) begin
               w_state_next = StSetup;
            end
         end
         StSetup: begin
            if (w_setup_done) begin
               w_state_next = StStrobe;
            end
         end
         StStrobe: begin
            if (w_pulse_done) begin
               w_state_next = StHold;
            end
         end
         StHold: begin
            // result_valid is high throughout HOLD, so ready alone is the handshake.
            if (result_ready) begin
               w_state_next = StNext;
            end
         end
         StNext: begin
            w_state_next = w_more ? StSetup : StDone;
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: outputs decoded from state
   // --------------------------------------------------------------------------
   always_comb begin
      bus_req      = 1'b1;
      busy         = 1'b1;
      CSN_o        = 1'b1;
      RDN_o        = 1'b1;
      result_valid = 1'b0;
      w_addr_en    = 1'b0;
      case (r_state)
         StIdle: begin
            bus_req = 1'b0;
            busy    = 1'b0;
         end
         StReq, StDone: begin
         end
         StSetup: begin
            CSN_o     = 1'b0;
            w_addr_en = 1'b1;
         end
         StStrobe: begin
            CSN_o     = 1'b0;
            RDN_o     = 1'b0;
            w_addr_en = 1'b1;
         end
         StHold: begin
            CSN_o        = 1'b0;
            result_valid = 1'b1;
            w_addr_en    = 1'b1;
         end
         StNext: begin
            // Chip select stays low across the register-to-register gap.
            CSN_o     = 1'b0;
            w_addr_en = 1'b1;
         end
         default: begin
            bus_req = 1'b0;
            busy    = 1'b0;
         end
      endcase
   end

   assign addr        = w_addr_en ? w_addr_cur : 4'd0;
   assign result      = r_result;
   assign result_addr = r_result_addr;
   assign overrun     = r_overrun;

   // --------------------------------------------------------------------------
   // Synchronizer, interrupt bookkeeping, counters and result capture
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_sync3       <= 1'b1;
         r_int_pend    <= 1'b0;
         r_requeue     <= 1'b0;
         r_overrun     <= 1'b0;
         r_idx         <= 3'd0;
         r_cnt         <= 4'd0;
         r_result      <= 28'd0;
         r_result_addr <= 4'd0;
      end else begin
         r_sync1 <= int_n;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;

         // A new edge beats the DONE clear so the interrupt is never lost.
         if (w_sync_edge) begin
            r_int_pend <= 1'b1;
         end else if (r_state == StDone) begin
            r_int_pend <= r_requeue;
         end

         if (r_state == StDone) begin
            r_requeue <= 1'b0;
         end else if (w_sync_edge && (r_state != StIdle)) begin
            r_requeue <= 1'b1;
         end

         if (w_sync_edge && (r_int_pend || (r_state != StIdle))) begin
            r_overrun <= 1'b1;
         end

         // Phase counter restarts whenever SETUP or STROBE completes.
         if ((r_state == StSetup && !w_setup_done) ||
             (r_state == StStrobe && !w_pulse_done)) begin
            r_cnt <= r_cnt + 4'd1;
         end else begin
            r_cnt <= 4'd0;
         end

         if (r_state == StIdle && w_state_next == StReq) begin
            r_idx <= 3'd0;
         end else if (r_state == StNext) begin
            r_idx <= r_idx + 3'd1;
         end

         if (r_state == StStrobe && w_pulse_done) begin
            r_result      <= data_i;
            r_result_addr <= w_addr_cur;
         end
      end
   end

endmodule

// File: tb/tb_tdc_read.sv
// -----------------------------------------------------------------------------
// tb_tdc_read
//
// Purpose: directed self-checking bench for tdc_read. A default-parameter
//   instance carries most scenarios; a minimum-timing instance (one register,
//   one setup cycle, one strobe cycle) shares the stimulus and is checked for
//   its chip-select and strobe widths.
// -----------------------------------------------------------------------------
module tb_tdc_read;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        init_done;
   logic        int_n;
   logic        bus_gnt;
   logic        result_ready;
   logic [27:0] data_i;

   logic        bus_req;
   logic        csn_o;
   logic        rdn_o;
   logic [3:0]  addr;
   logic [27:0] result;
   logic [3:0]  result_addr;
   logic        result_valid;
   logic        busy;
   logic        overrun;

   logic        bus_req_m;
   logic        csn_m;
   logic        rdn_m;
   logic [3:0]  addr_m;
   logic [27:0] result_m;
   logic [3:0]  result_addr_m;
   logic        result_valid_m;
   logic        busy_m;
   logic        overrun_m;

   tdc_read u_dut (
      .clk          (clk),
      .reset        (reset),
      .init_done    (init_done),
      .int_n        (int_n),
      .bus_gnt      (bus_gnt),
      .bus_req      (bus_req),
      .CSN_o        (csn_o),
      .RDN_o        (rdn_o),
      .addr         (addr),
      .data_i       (data_i),
      .result       (result),
      .result_addr  (result_addr),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .busy         (busy),
      .overrun      (overrun)
   );

   tdc_read #(
      .RD_SETUP (1),
      .RD_PULSE (1),
      .NUM_REG  (1)
   ) u_dut_min (
      .clk          (clk),
      .reset        (reset),
      .init_done    (init_done),
      .int_n        (int_n),
      .bus_gnt      (bus_gnt),
      .bus_req      (bus_req_m),
      .CSN_o        (csn_m),
      .RDN_o        (rdn_m),
      .addr         (addr_m),
      .data_i       (data_i),
      .result       (result_m),
      .result_addr  (result_addr_m),
      .result_valid (result_valid_m),
      .result_ready (result_ready),
      .busy         (busy_m),
      .overrun      (overrun_m)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Per-cycle observation counters, cleared at the start of each scenario.
   int cyc_n;
   int n_rdn, n_csn, n_rdn1, n_csn1, n_breq, n_proto;
   int n_busy_rise, first_busy_cyc, first_csn_cyc;
   int n_vrise, n_vfall, vlen, vlen1, n_unstable, n_a9_early;
   logic        prev_rdn, prev_valid, prev_busy;
   logic [27:0] hold_res;
   logic [3:0]  hold_raddr, hold_addr;
   logic [3:0]  rdn_addr_q[$];
   logic [3:0]  hs_addr_q[$];
   logic [27:0] hs_data_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rdn_addr_at(input int i);
      if (i < rdn_addr_q.size()) return 32'(rdn_addr_q[i]);
      return 32'hDEAD;
   endfunction

   function automatic logic [31:0] hs_addr_at(input int i);
      if (i < hs_addr_q.size()) return 32'(hs_addr_q[i]);
      return 32'hDEAD;
   endfunction

   function automatic logic [31:0] hs_data_at(input int i);
      if (i < hs_data_q.size()) return 32'(hs_data_q[i]);
      return 32'hDEAD;
   endfunction

   task automatic clear_mon();
      n_rdn = 0; n_csn = 0; n_rdn1 = 0; n_csn1 = 0; n_breq = 0; n_proto = 0;
      n_busy_rise = 0; first_busy_cyc = -1; first_csn_cyc = -1;
      n_vrise = 0; n_vfall = 0; vlen = 0; vlen1 = 0; n_unstable = 0; n_a9_early = 0;
      prev_rdn = rdn_o; prev_valid = result_valid; prev_busy = busy;
      rdn_addr_q.delete();
      hs_addr_q.delete();
      hs_data_q.delete();
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
      if (!rdn_o) begin
         n_rdn++;
         if (prev_rdn) rdn_addr_q.push_back(addr);
         if (csn_o) n_proto++;
      end
      if (!csn_o) begin
         n_csn++;
         if (first_csn_cyc < 0) first_csn_cyc = cyc_n;
      end
      if (!rdn_m) n_rdn1++;
      if (!csn_m) n_csn1++;
      if (bus_req) n_breq++;
      if (busy && !prev_busy) begin
         n_busy_rise++;
         if (first_busy_cyc < 0) first_busy_cyc = cyc_n;
      end
      if (prev_valid && !result_valid) n_vfall++;
      if (result_valid) begin
         if (!prev_valid) begin
            n_vrise++;
            vlen       = 0;
            hold_res   = result;
            hold_raddr = result_addr;
            hold_addr  = addr;
            hs_addr_q.push_back(result_addr);
            hs_data_q.push_back(result);
         end else if (result !== hold_res || result_addr !== hold_raddr ||
                      addr !== hold_addr) begin
            n_unstable++;
         end
         if (csn_o) n_unstable++;
         vlen++;
         if (n_vrise == 1) vlen1 = vlen;
      end
      if (addr == 4'd9 && n_vfall == 0) n_a9_early++;
      prev_rdn   = rdn_o;
      prev_valid = result_valid;
      prev_busy  = busy;
   endtask

   task automatic pulse_int();
      int_n = 1'b0;
      cyc();
      int_n = 1'b1;
   endtask

   task automatic do_reset();
      init_done    = 1'b1;
      int_n        = 1'b1;
      bus_gnt      = 1'b1;
      result_ready = 1'b1;
      data_i       = 28'h0ABCDEF;
      reset        = 1'b1;
      cyc();
      cyc();
      reset        = 1'b0;
   endtask

   // Runs until a sequence has started and the block is idle again.
   task automatic wait_idle(input int budget, input string tag);
      int  k;
      logic done;
      k    = 0;
      done = 1'b0;
      while (!done && k < budget) begin
         cyc();
         k++;
         if (n_busy_rise > 0 && !busy) done = 1'b1;
      end
      check_eq({tag, "_timeout"}, done, 1);
   endtask

   initial begin
      int   t0;
      int   k;
      logic found;
      cyc_n = 0;

      // Reset state
      do_reset();
      check_eq("rst_csn", csn_o, 1);
      check_eq("rst_rdn", rdn_o, 1);
      check_eq("rst_addr", addr, 0);
      check_eq("rst_result", result, 0);
      check_eq("rst_raddr", result_addr, 0);
      check_eq("rst_valid", result_valid, 0);
      check_eq("rst_busreq", bus_req, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_overrun", overrun, 0);
      clear_mon();
      repeat (10) cyc();
      check_eq("rst_quiet", n_busy_rise, 0);

      // Basic two-register read
      clear_mon();
      t0 = cyc_n;
      pulse_int();
      wait_idle(60, "t1");
      check_eq("t1_latency", first_busy_cyc - t0, 4);
      check_eq("t1_rdn_cycles", n_rdn, 6);
      check_eq("t1_csn_cycles", n_csn, 14);
      check_eq("t1_busreq_cycles", n_breq, 16);
      check_eq("t1_rdn_without_csn", n_proto, 0);
      check_eq("t1_rdn_count", rdn_addr_q.size(), 2);
      check_eq("t1_rdn_addr0", rdn_addr_at(0), 8);
      check_eq("t1_rdn_addr1", rdn_addr_at(1), 9);
      check_eq("t1_valid_pulses", n_vrise, 2);
      check_eq("t1_raddr0", hs_addr_at(0), 8);
      check_eq("t1_raddr1", hs_addr_at(1), 9);
      check_eq("t1_data0", hs_data_at(0), 32'h0ABCDEF);
      check_eq("t1_data1", hs_data_at(1), 32'h0ABCDEF);
      check_eq("t1_overrun", overrun, 0);
      check_eq("t1_busy_end", busy, 0);
      check_eq("min_csn_cycles", n_csn1, 4);
      check_eq("min_rdn_cycles", n_rdn1, 1);
      check_eq("min_raddr", result_addr_m, 8);
      check_eq("min_busy_end", busy_m, 0);

      // Consumer stalls 10 cycles on the first result
      do_reset();
      clear_mon();
      result_ready = 1'b0;
      data_i       = 28'h1234567;
      pulse_int();
      k     = 0;
      found = 1'b0;
      while (!found && k < 80) begin
         cyc();
         k++;
         if (n_vrise == 1 && vlen == 1) data_i = 28'h7654321;
         if (n_vrise == 1 && vlen1 == 10 && result_valid) result_ready = 1'b1;
         if (n_busy_rise > 0 && !busy) found = 1'b1;
      end
      check_eq("t2_timeout", found, 1);
      check_eq("t2_stall_len", vlen1, 10);
      check_eq("t2_unstable", n_unstable, 0);
      check_eq("t2_addr9_early", n_a9_early, 0);
      check_eq("t2_data0", hs_data_at(0), 32'h1234567);
      check_eq("t2_data1", hs_data_at(1), 32'h7654321);
      check_eq("t2_raddr1", hs_addr_at(1), 9);
      check_eq("t2_rdn_addr1", rdn_addr_at(1), 9);

      // Interrupt held off by init_done
      do_reset();
      clear_mon();
      init_done = 1'b0;
      pulse_int();
      repeat (50) cyc();
      check_eq("t3_csn_quiet", n_csn, 0);
      check_eq("t3_rdn_quiet", n_rdn, 0);
      check_eq("t3_busreq_quiet", n_breq, 0);
      t0        = cyc_n;
      init_done = 1'b1;
      wait_idle(60, "t3");
      check_eq("t3_start_latency", first_csn_cyc - t0, 2);
      check_eq("t3_valid_pulses", n_vrise, 2);

      // Second interrupt during the first strobe
      do_reset();
      clear_mon();
      pulse_int();
      k     = 0;
      found = 1'b0;
      while (!found && k < 30) begin
         cyc();
         k++;
         if (!rdn_o) found = 1'b1;
      end
      check_eq("t4_strobe_seen", found, 1);
      check_eq("t4_overrun_before", overrun, 0);
      pulse_int();
      repeat (80) cyc();
      check_eq("t4_overrun", overrun, 1);
      check_eq("t4_sequences", n_busy_rise, 2);
      check_eq("t4_valid_pulses", n_vrise, 4);
      check_eq("t4_strobes", rdn_addr_q.size(), 4);
      check_eq("t4_busy_end", busy, 0);

      // Reset on the second strobe cycle
      do_reset();
      clear_mon();
      pulse_int();
      k = 0;
      while (n_rdn < 2 && k < 30) begin
         cyc();
         k++;
      end
      check_eq("t5_strobe2_seen", n_rdn, 2);
      reset = 1'b1;
      cyc();
      check_eq("t5_csn", csn_o, 1);
      check_eq("t5_rdn", rdn_o, 1);
      check_eq("t5_valid", result_valid, 0);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_busreq", bus_req, 0);
      reset = 1'b0;
      clear_mon();
      repeat (30) cyc();
      check_eq("t5_idle_busy", n_busy_rise, 0);
      check_eq("t5_idle_csn", n_csn, 0);

      // Grant withheld, then dropped right after being given
      do_reset();
      clear_mon();
      bus_gnt = 1'b0;
      pulse_int();
      repeat (10) cyc();
      check_eq("t6_req_waiting", bus_req, 1);
      check_eq("t6_busy_waiting", busy, 1);
      check_eq("t6_csn_waiting", n_csn, 0);
      bus_gnt = 1'b1;
      cyc();
      bus_gnt = 1'b0;
      wait_idle(60, "t6");
      check_eq("t6_valid_pulses", n_vrise, 2);
      check_eq("t6_rdn_cycles", n_rdn, 6);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
